dispatch_alloc: RTL and testbench



---
 rtl/dispatch_alloc.sv | 146 ++++++++++++++
 tb/tb_dispatch_alloc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_alloc.sv
// In-order tag allocator: two-wide dispatch into a DEPTH-entry circular reorder window.
// Optional retire-underflow checking is enabled by defining YSYX22040228_ALLOC_ERRCHK_EN.
module dispatch_alloc #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 64,
    parameter int unsigned RA_W  = 5,
    localparam int unsigned TW   = $clog2(DEPTH),
    localparam int unsigned CW   = TW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in1_valid,
    input  logic [PC_W-1:0] in1_pc,
    input  logic [RA_W-1:0] in1_rd,
    input  logic            in1_rdena,
    input  logic            in2_valid,
    input  logic [PC_W-1:0] in2_pc,
    input  logic [RA_W-1:0] in2_rd,
    input  logic            in2_rdena,
    output logic            alloc_stop,
    output logic            out1_valid,
    output logic [TW-1:0]   out1_tag,
    output logic [PC_W-1:0] out1_pc,
    output logic [RA_W-1:0] out1_rd,
    output logic            out1_rdena,
    output logic            out2_valid,
    output logic [TW-1:0]   out2_tag,
    output logic [PC_W-1:0] out2_pc,
    output logic [RA_W-1:0] out2_rd,
    output logic            out2_rdena,
    input  logic [1:0]      ret_cnt,
    input  logic [TW-1:0]   lk_tag,
    output logic [PC_W-1:0] lk_pc,
    output logic [RA_W-1:0] lk_rd,
    output logic            lk_rdena,
    output logic [TW-1:0]   head_tag,
    output logic [TW-1:0]   tail_tag,
    output logic [CW-1:0]   count,
    output logic            err_underflow
);

    logic [TW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PC_W-1:0] pc_q    [DEPTH];
    logic [RA_W-1:0] rd_q    [DEPTH];
    logic            rdena_q [DEPTH];
    logic            wr1, wr2, under;
    logic [1:0]      nalloc, ret_lim, nret;

    assign alloc_stop = (count_q > CW'(DEPTH - 2));

    always_comb begin
        wr1     = in1_valid & ~alloc_stop & ~flush;
        wr2     = wr1 & in2_valid;
        nalloc  = {1'b0, wr1} + {1'b0, wr2};
        ret_lim = (ret_cnt == 2'd3) ? 2'd2 : ret_cnt;
        under   = 1'b0;
`ifdef YSYX22040228_ALLOC_ERRCHK_EN
        under   = (CW'(ret_cnt) > count_q);
        // count below 2 here, so its low bits hold the clamped value
        nret    = (CW'(ret_lim) > count_q) ? count_q[1:0] : ret_lim;
`else
        nret    = ret_lim;
`endif
        head_d  = head_q + TW'(nret);
        tail_d  = tail_q + TW'(nalloc);
        count_d = count_q + CW'(nalloc) - CW'(nret);
    end

    always_ff @(posedge clk) begin
        if (wr1) begin
            pc_q[tail_q]    <= in1_pc;
            rd_q[tail_q]    <= in1_rd;
            rdena_q[tail_q] <= in1_rdena;
        end
        if (wr2) begin
            pc_q[tail_q + TW'(1)]    <= in2_pc;
            rd_q[tail_q + TW'(1)]    <= in2_rd;
            rdena_q[tail_q + TW'(1)] <= in2_rdena;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
            out1_tag   <= '0;
            out2_tag   <= '0;
            out1_pc    <= '0;
            out2_pc    <= '0;
            out1_rd    <= '0;
            out2_rd    <= '0;
            out1_rdena <= 1'b0;
            out2_rdena <= 1'b0;
        end else if (flush) begin
            // head is kept so tags stay monotonic across the squash
            tail_q     <= head_q;
            count_q    <= '0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out1_valid <= wr1;
            out2_valid <= wr2;
            if (wr1) begin
                out1_tag   <= tail_q;
                out1_pc    <= in1_pc;
                out1_rd    <= in1_rd;
                out1_rdena <= in1_rdena;
            end
            if (wr2) begin
                out2_tag   <= tail_q + TW'(1);
                out2_pc    <= in2_pc;
                out2_rd    <= in2_rd;
                out2_rdena <= in2_rdena;
            end
        end
    end

`ifdef YSYX22040228_ALLOC_ERRCHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (!flush && under)
            err_q <= 1'b1;
    end
    assign err_underflow = err_q;
`else
    assign err_underflow = 1'b0;
`endif

    assign lk_pc    = pc_q[lk_tag];
    assign lk_rd    = rd_q[lk_tag];
    assign lk_rdena = rdena_q[lk_tag];
    assign head_tag = head_q;
    assign tail_tag = tail_q;
    assign count    = count_q;

endmodule

// File: tb/tb_dispatch_alloc.sv
// Scoreboard bench for dispatch_alloc: directed allocate/retire/flush/wrap sequence.
module tb_dispatch_alloc;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in1_valid, in1_rdena, in2_valid, in2_rdena;
    logic [63:0] in1_pc, in2_pc;
    logic [4:0]  in1_rd, in2_rd;
    logic        alloc_stop;
    logic        out1_valid, out1_rdena, out2_valid, out2_rdena;
    logic [2:0]  out1_tag, out2_tag;
    logic [63:0] out1_pc, out2_pc;
    logic [4:0]  out1_rd, out2_rd;
    logic [1:0]  ret_cnt;
    logic [2:0]  lk_tag;
    logic [63:0] lk_pc;
    logic [4:0]  lk_rd;
    logic        lk_rdena;
    logic [2:0]  head_tag, tail_tag;
    logic [3:0]  count;
    logic        err_underflow;

    dispatch_alloc #(.DEPTH(8), .PC_W(64), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_rd(in1_rd), .in1_rdena(in1_rdena),
        .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_rd(in2_rd), .in2_rdena(in2_rdena),
        .alloc_stop(alloc_stop),
        .out1_valid(out1_valid), .out1_tag(out1_tag), .out1_pc(out1_pc),
        .out1_rd(out1_rd), .out1_rdena(out1_rdena),
        .out2_valid(out2_valid), .out2_tag(out2_tag), .out2_pc(out2_pc),
        .out2_rd(out2_rd), .out2_rdena(out2_rdena),
        .ret_cnt(ret_cnt), .lk_tag(lk_tag), .lk_pc(lk_pc), .lk_rd(lk_rd), .lk_rdena(lk_rdena),
        .head_tag(head_tag), .tail_tag(tail_tag), .count(count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v2;
        logic [2:0]  t1, t2;
        logic [63:0] p1, p2;
        logic [4:0]  r1, r2;
        logic        e1, e2;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  m_head, m_tail;
    int unsigned m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented allocation must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out2_valid && !out1_valid) chk("out2_without_out1", 64'(out2_valid), 64'd0);
            if (out1_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out1_valid", 64'(out1_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out1_tag", 64'(out1_tag), 64'(e.t1));
                    chk("out1_pc", out1_pc, e.p1);
                    chk("out1_rd", 64'(out1_rd), 64'(e.r1));
                    chk("out1_rdena", 64'(out1_rdena), 64'(e.e1));
                    chk("out2_valid", 64'(out2_valid), 64'(e.v2));
                    if (e.v2) begin
                        chk("out2_tag", 64'(out2_tag), 64'(e.t2));
                        chk("out2_pc", out2_pc, e.p2);
                        chk("out2_rd", 64'(out2_rd), 64'(e.r2));
                        chk("out2_rdena", 64'(out2_rdena), 64'(e.e2));
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        flush = 1'b0; ret_cnt = 2'd0;
        in1_valid = 1'b0; in1_pc = '0; in1_rd = '0; in1_rdena = 1'b0;
        in2_valid = 1'b0; in2_pc = '0; in2_rd = '0; in2_rdena = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(m_count));
        chk({tag, "_head"}, 64'(head_tag), 64'(m_head));
        chk({tag, "_tail"}, 64'(tail_tag), 64'(m_tail));
        chk({tag, "_stop"}, 64'(alloc_stop), 64'(m_count > 6));
    endtask

    task automatic step(input string tag, input logic a1, input logic a2,
                        input logic [63:0] p1, input logic [63:0] p2,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic e1, input logic e2,
                        input logic [1:0] ret, input logic fl);
        exp_t        e;
        int unsigned na, nr;
        in1_valid = a1; in1_pc = p1; in1_rd = r1; in1_rdena = e1;
        in2_valid = a2; in2_pc = p2; in2_rd = r2; in2_rdena = e2;
        ret_cnt = ret; flush = fl;
        if (fl) begin
            m_tail  = m_head;
            m_count = 0;
        end else begin
            na = 0;
            if (m_count <= 6 && a1) begin
                na   = a2 ? 2 : 1;
                e.v2 = a2; e.t1 = m_tail; e.t2 = 3'(m_tail + 3'd1);
                e.p1 = p1; e.p2 = p2; e.r1 = r1; e.r2 = r2; e.e1 = e1; e.e2 = e2;
                q.push_back(e);
            end
            nr = (ret == 2'd3) ? 2 : int'(ret);
            if (nr > m_count) nr = m_count;
            m_head  = 3'(m_head + 3'(nr));
            m_tail  = 3'(m_tail + 3'(na));
            m_count = m_count + na - nr;
        end
        @(posedge clk);
        #1;
        clear_inputs();
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        lk_tag = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_head = '0; m_tail = '0; m_count = 0;
        check_state("reset");
        chk("reset_out1_valid", 64'(out1_valid), 64'd0);
        chk("reset_out2_valid", 64'(out2_valid), 64'd0);
        chk("reset_err", 64'(err_underflow), 64'd0);

        // first pair, then fill to 8 and try one more pair while stopped
        step("pair0", 1, 1, 64'h8000_0000, 64'h8000_0004, 5'd1, 5'd2, 1, 1, 2'd0, 0);
        lk_tag = 3'd1; #1;
        chk("lk_pc_tag1", lk_pc, 64'h8000_0004);
        chk("lk_rd_tag1", 64'(lk_rd), 64'd2);
        step("pair1", 1, 1, 64'h8000_0008, 64'h8000_000c, 5'd3, 5'd4, 0, 1, 2'd0, 0);
        step("pair2", 1, 1, 64'h8000_0010, 64'h8000_0014, 5'd5, 5'd6, 1, 0, 2'd0, 0);
        step("pair3", 1, 1, 64'h8000_0018, 64'h8000_001c, 5'd7, 5'd8, 1, 1, 2'd0, 0);
        chk("full_count", 64'(count), 64'd8);
        step("stalled", 1, 1, 64'h8000_0020, 64'h8000_0024, 5'd9, 5'd10, 1, 1, 2'd0, 0);
        chk("stalled_out1_valid", 64'(out1_valid), 64'd0);
        step("ret_a", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        chk("ret_a_stop_low", 64'(alloc_stop), 64'd0);
        step("ret_b", 0, 0, '0, '0, '0, '0, 0, 0, 2'd3, 0);
        step("ret_c", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        step("ret_d", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        step("empty_ret", 0, 0, '0, '0, '0, '0, 0, 0, 2'd0, 0);

        // simultaneous allocate and retire at count 4
        step("pair4", 1, 1, 64'h1000, 64'h1004, 5'd11, 5'd12, 1, 1, 2'd0, 0);
        step("pair5", 1, 1, 64'h1008, 64'h100c, 5'd13, 5'd14, 1, 1, 2'd0, 0);
        step("simul", 1, 1, 64'h1010, 64'h1014, 5'd15, 5'd16, 1, 0, 2'd2, 0);
        chk("simul_count4", 64'(count), 64'd4);
        step("single", 1, 0, 64'h1018, 64'h0, 5'd17, 5'd0, 1, 0, 2'd1, 0);
        step("drain_a", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        step("drain_b", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        chk("pre_wrap_head", 64'(head_tag), 64'd7);

        // pair straddling the tag wrap
        step("wrap", 1, 1, 64'h2000, 64'h2004, 5'd18, 5'd19, 1, 1, 2'd0, 0);
        lk_tag = 3'd0; #1;
        chk("lk_pc_tag0", lk_pc, 64'h2004);
        chk("lk_rdena_tag0", 64'(lk_rdena), 64'd1);
        step("single2", 1, 0, 64'h2008, 64'h0, 5'd20, 5'd0, 0, 0, 2'd0, 0);

        // flush with a pair and a retire pending at count 3
        step("flush", 1, 1, 64'h3000, 64'h3004, 5'd21, 5'd22, 1, 1, 2'd1, 1);
        chk("flush_out1_valid", 64'(out1_valid), 64'd0);
        chk("flush_out2_valid", 64'(out2_valid), 64'd0);

`ifdef YSYX22040228_ALLOC_ERRCHK_EN
        step("err_alloc", 1, 0, 64'h4000, 64'h0, 5'd23, 5'd0, 1, 0, 2'd0, 0);
        step("err_ret", 0, 0, '0, '0, '0, '0, 0, 0, 2'd2, 0);
        chk("err_set", 64'(err_underflow), 64'd1);
        step("err_flush", 0, 0, '0, '0, '0, '0, 0, 0, 2'd0, 1);
        chk("err_after_flush", 64'(err_underflow), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_head = '0; m_tail = '0; m_count = 0;
        chk("err_cleared", 64'(err_underflow), 64'd0);
        check_state("rst2");
`else
        chk("err_tied_low", 64'(err_underflow), 64'd0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
